imm_encode_insert: RTL and testbench
====================================

// Module: imm_encode_insert
// PURPOSE
// - Inverse of the decode-stage immediate extractor. Takes a base RV32I instruction word, a 32-bit immediate value
//   and an immediate type, and scatters the immediate into that type's instruction bit fields.
// - Two-stage valid/ready pipeline with per-stage stall. Feeds the instruction-memory patch/program-load path.
// - Optional range/alignment checker with a saturating error counter.
// PARAMETERS
// - ERR_CNT_W  16  width of the saturating error counter o_err_cnt
// PORTS
// - clk          in   1   clock; all state updates on its rising edge
// - reset_n      in   1   synchronous, active-low reset
// - i_valid      in   1   input request valid
// - o_ready      out  1   input can be accepted this cycle
// - i_base_instr in   32  instruction word; non-immediate fields (opcode/rd/rs1/rs2/funct) are kept
// - i_imm        in   32  immediate value, two's complement
// - i_imm_sel    in   3   000=U 001=I 010=S 011=B 100=J; 101/110/111 illegal
// - o_valid      out  1   output word valid
// - i_ready      in   1   downstream accepts the output word
// - o_instr      out  32  encoded instruction
// - o_err        out  1   output word failed the range/alignment check (qualified by o_valid)
// - o_err_cnt    out  ERR_CNT_W  count of erroneous words accepted by downstream, saturating
// BEHAVIOUR
// - Reset (reset_n=0 at a clock edge): both stage valids=0, o_valid=0, o_err=0, o_err_cnt=0, o_instr=0.
//   Reset wins over any concurrent handshake; in-flight words are dropped, not completed.
// - Handshake: transfer on i_valid&o_ready (input) and o_valid&i_ready (output). o_valid, o_instr and o_err hold
//   stable while o_valid&!i_ready.
// - Stage S1 registers {base, imm, sel} and the check result. Stage S2 registers the encoded word and o_err.
// - Stage advance: S2 loads when it is empty or draining; S1 loads when it is empty or moving into S2.
//   o_ready = !S1.valid | S2 can load. This is a combinational path from i_ready.
// - Latency: 2 cycles from input acceptance to o_valid. Throughput: 1 word/cycle when i_ready=1.
// - Encoding, with all other bits copied from i_base_instr:
//   - U: [31:12]=imm[31:12]
//   - I: [31:20]=imm[11:0]
//   - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
//   - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
//   - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
//   - Illegal sel: i_base_instr is passed through unchanged.
// - Immediate bits that do not fit are truncated silently. The output word is always produced, never dropped.
// - Error counter: increments by 1 on each output transfer with o_err=1 and holds at all-ones.
// CONFIGURATION
// - Macro IMM_RANGE_CHECK_EN defined: S1 computes err, true if any of the following holds:
//   - U: imm[11:0]!=0
//   - I/S: imm[31:11] not all-equal
//   - B: imm[31:12] not all-equal or imm[0]=1
//   - J: imm[31:20] not all-equal or imm[0]=1
//   - illegal sel
//   o_err and o_err_cnt behave as described under BEHAVIOUR.
// - Macro not defined: no check logic; o_err tied 0, o_err_cnt tied 0. Encoding and timing are identical.
// TESTING
// - I: base=0x00000093, imm=0xFFFFFFFF, sel=001, i_ready=1 -> o_instr=0xFFF00093 two cycles later, o_err=0.
// - U/B/J: base 0x000000B7 imm 0x12345000 sel 000 -> 0x123450B7; base 0x00000063 imm 0x8 sel 011 -> 0x00000463;
//   base 0x0000006F imm 0xFFFFFFFC sel 100 -> 0xFFDFF06F. Issue back-to-back, 1 word/cycle.
// - With IMM_RANGE_CHECK_EN: I imm=0x800 -> o_instr=0x80000093, o_err=1; B imm=0x3 -> err=1.
//   sel=101 -> o_instr=base, err=1. o_err_cnt=3 after all three words transfer.
// - Backpressure: hold i_ready=0 for 5 cycles with 3 words offered -> exactly 2 accepted, o_ready=0, o_instr stable.
//   Release i_ready -> all words emerge in order, none lost or duplicated.
// - Reset mid-op: pull reset_n=0 for 1 cycle while both stages are full -> o_valid=0 and o_err_cnt=0 next cycle.
//   The first new word appears 2 cycles after its acceptance.
// - Saturation: ERR_CNT_W=2 with 5 erroneous transfers -> o_err_cnt stops at 3.

Source files
------------

// File: rtl/imm_encode_insert_if.sv
// Request/response bus of the immediate encoder: input word handshake, output word handshake, error status.
interface imm_encode_insert_if #(
    parameter int unsigned ERR_CNT_W = 16
);
    logic                 i_valid;
    logic                 o_ready;
    logic [31:0]          i_base_instr;
    logic [31:0]          i_imm;
    logic [2:0]           i_imm_sel;
    logic                 o_valid;
    logic                 i_ready;
    logic [31:0]          o_instr;
    logic                 o_err;
    logic [ERR_CNT_W-1:0] o_err_cnt;

    modport slave (
        input  i_valid, i_base_instr, i_imm, i_imm_sel, i_ready,
        output o_ready, o_valid, o_instr, o_err, o_err_cnt
    );

    modport master (
        output i_valid, i_base_instr, i_imm, i_imm_sel, i_ready,
        input  o_ready, o_valid, o_instr, o_err, o_err_cnt
    );
endinterface

// File: rtl/imm_encode_insert.sv
// Two-stage pipeline that scatters a 32-bit immediate into the U/I/S/B/J fields of an RV32I word.
// Optional range/alignment checker and saturating error counter enabled by macro IMM_RANGE_CHECK_EN.
module imm_encode_insert #(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    imm_encode_insert_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_U = 3'd0;
    localparam logic [SEL_W-1:0] SEL_I = 3'd1;
    localparam logic [SEL_W-1:0] SEL_S = 3'd2;
    localparam logic [SEL_W-1:0] SEL_B = 3'd3;
    localparam logic [SEL_W-1:0] SEL_J = 3'd4;

    logic             s1_valid;
    logic [XLEN-1:0]  s1_base;
    logic [XLEN-1:0]  s1_imm;
    logic [SEL_W-1:0] s1_sel;
    logic             s1_load;
    logic             s2_load;
    logic             out_xfer;

    // Field scatter; unsupported selectors leave the base word untouched.
    function automatic logic [XLEN-1:0] encode(input logic [XLEN-1:0] base,
                                               input logic [XLEN-1:0] imm,
                                               input logic [SEL_W-1:0] sel);
        logic [XLEN-1:0] word;
        case (sel)
            SEL_U:   word = {imm[31:12], base[11:0]};
            SEL_I:   word = {imm[11:0], base[19:0]};
            SEL_S:   word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
            SEL_B:   word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
            SEL_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
            default: word = base;
        endcase
        return word;
    endfunction

    assign s2_load     = !bus.o_valid || bus.i_ready;
    assign s1_load     = !s1_valid || s2_load;
    assign bus.o_ready = s1_load;
    assign out_xfer    = bus.o_valid && bus.i_ready;

    // Pipeline valids and data; reset drops any words in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_base     <= '0;
            s1_imm      <= '0;
            s1_sel      <= '0;
            bus.o_valid <= 1'b0;
            bus.o_instr <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.i_valid;
                if (bus.i_valid) begin
                    s1_base <= bus.i_base_instr;
                    s1_imm  <= bus.i_imm;
                    s1_sel  <= bus.i_imm_sel;
                end
            end
            if (s2_load) begin
                bus.o_valid <= s1_valid;
                if (s1_valid) begin
                    bus.o_instr <= encode(s1_base, s1_imm, s1_sel);
                end
            end
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic in_err_c;
    logic s1_err;

    // An immediate fits when the bits above the field are a sign extension and dropped low bits are zero.
    always_comb begin
        in_err_c = 1'b0;
        case (bus.i_imm_sel)
            SEL_U:   in_err_c = |bus.i_imm[11:0];
            SEL_I,
            SEL_S:   in_err_c = bus.i_imm[31:11] != {21{bus.i_imm[31]}};
            SEL_B:   in_err_c = (bus.i_imm[31:12] != {20{bus.i_imm[31]}}) || bus.i_imm[0];
            SEL_J:   in_err_c = (bus.i_imm[31:20] != {12{bus.i_imm[31]}}) || bus.i_imm[0];
            default: in_err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_err        <= 1'b0;
            bus.o_err     <= 1'b0;
            bus.o_err_cnt <= '0;
        end else begin
            if (s1_load && bus.i_valid) begin
                s1_err <= in_err_c;
            end
            if (s2_load && s1_valid) begin
                bus.o_err <= s1_err;
            end
            if (out_xfer && bus.o_err && (bus.o_err_cnt != CNT_MAX)) begin
                bus.o_err_cnt <= bus.o_err_cnt + ERR_CNT_W'(1);
            end
        end
    end
`else
    assign bus.o_err     = 1'b0;
    assign bus.o_err_cnt = ERR_CNT_W'(0);

    logic unused_c;
    assign unused_c = out_xfer;
`endif

endmodule

// File: tb/tb_imm_encode_insert.sv
// Randomised and directed bench for imm_encode_insert against a bit-mapping reference model.
module tb_imm_encode_insert;
    localparam int unsigned CW = 2;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cnt_m  = 0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        in_s2;
    } ent_t;

    ent_t q[$];

    imm_encode_insert_if #(.ERR_CNT_W(CW)) bus ();

    imm_encode_insert #(.ERR_CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Immediate bit feeding instruction bit p, or -1 when p keeps the base bit.
    function automatic int src_idx(input logic [2:0] sel, input int p);
        case (sel)
            3'd0: return (p >= 12) ? p : -1;
            3'd1: return (p >= 20) ? p - 20 : -1;
            3'd2: begin
                if (p >= 25) return p - 20;
                if (p >= 7 && p <= 11) return p - 7;
                return -1;
            end
            3'd3: begin
                if (p == 31) return 12;
                if (p >= 25 && p <= 30) return p - 20;
                if (p >= 8 && p <= 11) return p - 7;
                if (p == 7) return 11;
                return -1;
            end
            3'd4: begin
                if (p == 31) return 20;
                if (p >= 21 && p <= 30) return p - 20;
                if (p == 20) return 11;
                if (p >= 12 && p <= 19) return p;
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] ref_enc(input logic [31:0] base, input logic [31:0] imm,
                                            input logic [2:0] sel);
        logic [31:0] w;
        w = base;
        for (int p = 0; p < 32; p++) begin
            int s;
            s = src_idx(sel, p);
            if (s >= 0) w[p] = imm[s];
        end
        return w;
    endfunction

    function automatic logic ref_err(input logic [31:0] imm, input logic [2:0] sel);
`ifdef IMM_RANGE_CHECK_EN
        longint v;
        v = longint'($signed(imm));
        case (sel)
            3'd0:    return (imm % 4096) != 0;
            3'd1,
            3'd2:    return (v < -2048) || (v > 2047);
            3'd3:    return (v < -4096) || (v > 4095) || (v % 2 != 0);
            3'd4:    return (v < -1048576) || (v > 1048575) || (v % 2 != 0);
            default: return 1'b1;
        endcase
`else
        return (imm === 32'hx) && (sel === 3'bx);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check against the model, then advance the model across the edge.
    task automatic cyc(input logic v, input logic [31:0] b, input logic [31:0] imm,
                       input logic [2:0] s, input logic rdy, output logic acc);
        logic exp_ready;
        logic exp_valid;
        ent_t e;
        @(negedge clk);
        bus.i_valid      = v;
        bus.i_base_instr = b;
        bus.i_imm        = imm;
        bus.i_imm_sel    = s;
        bus.i_ready      = rdy;
        #1;
        exp_ready = (q.size() < 2) || rdy;
        exp_valid = (q.size() > 0) && q[0].in_s2;
        chk("o_ready", 32'(bus.o_ready), 32'(exp_ready));
        chk("o_valid", 32'(bus.o_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("o_instr", bus.o_instr, q[0].instr);
            chk("o_err", 32'(bus.o_err), 32'(q[0].err));
        end
        chk("o_err_cnt", 32'(bus.o_err_cnt), 32'(cnt_m));
        if (exp_valid && rdy) begin
            if (q[0].err && cnt_m < (1 << CW) - 1) cnt_m++;
            void'(q.pop_front());
        end
        if (q.size() > 0 && !q[0].in_s2) q[0].in_s2 = 1'b1;
        acc = v && exp_ready;
        if (acc) begin
            e.instr = ref_enc(b, imm, s);
            e.err   = ref_err(imm, s);
            e.in_s2 = 1'b0;
            q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, a);
    endtask

    initial begin
        logic        a;
        logic [31:0] bp_base [3];
        int          k;
        logic [31:0] held;

        reset_n          = 1'b0;
        bus.i_valid      = 1'b0;
        bus.i_base_instr = '0;
        bus.i_imm        = '0;
        bus.i_imm_sel    = '0;
        bus.i_ready      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_o_err", 32'(bus.o_err), 32'h0);
        chk("rst_o_err_cnt", 32'(bus.o_err_cnt), 32'h0);
        chk("rst_o_instr", bus.o_instr, 32'h0);
        reset_n = 1'b1;

        // I-type sign extension example, two cycles to output
        cyc(1'b1, 32'h00000093, 32'hFFFFFFFF, 3'd1, 1'b1, a);
        cyc(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, a);
        #1;
        chk("i_enc", bus.o_instr, 32'hFFF00093);
        chk("i_err", 32'(bus.o_err), 32'h0);

        // U/B/J back to back
        cyc(1'b1, 32'h000000B7, 32'h12345000, 3'd0, 1'b1, a);
        cyc(1'b1, 32'h00000063, 32'h00000008, 3'd3, 1'b1, a);
        #1 chk("u_enc", bus.o_instr, 32'h123450B7);
        cyc(1'b1, 32'h0000006F, 32'hFFFFFFFC, 3'd4, 1'b1, a);
        #1 chk("b_enc", bus.o_instr, 32'h00000463);
        cyc(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, a);
        #1 chk("j_enc", bus.o_instr, 32'hFFDFF06F);
        chk("ubj_valid", 32'(bus.o_valid), 32'h1);

        // Out-of-range and illegal selector words
        cyc(1'b1, 32'h00000093, 32'h00000800, 3'd1, 1'b1, a);
        cyc(1'b1, 32'h00000063, 32'h00000003, 3'd3, 1'b1, a);
        #1 chk("rng_i_enc", bus.o_instr, 32'h80000093);
        cyc(1'b1, 32'h12345678, 32'hDEADBEEF, 3'd5, 1'b1, a);
        cyc(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, a);
        #1 chk("ill_enc", bus.o_instr, 32'h12345678);
`ifdef IMM_RANGE_CHECK_EN
        chk("ill_err", 32'(bus.o_err), 32'h1);
`endif
        idle(2);
`ifdef IMM_RANGE_CHECK_EN
        chk("cnt_after3", 32'(bus.o_err_cnt), 32'd3);
`else
        chk("cnt_after3", 32'(bus.o_err_cnt), 32'd0);
`endif

        // Counter saturation with five more erroneous words
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h00000013, 32'(i), 3'd6, 1'b1, a);
        idle(3);
`ifdef IMM_RANGE_CHECK_EN
        chk("cnt_sat", 32'(bus.o_err_cnt), 32'd3);
`else
        chk("cnt_sat", 32'(bus.o_err_cnt), 32'd0);
`endif

        // Backpressure: three words offered with the sink stalled for five cycles
        bp_base[0] = 32'h00000013;
        bp_base[1] = 32'h00100093;
        bp_base[2] = 32'h00200113;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, bp_base[k % 3], 32'h00000040 + 32'(k), 3'd1, 1'b0, a);
            if (a) k++;
            if (i == 2) held = bus.o_instr;
        end
        #1;
        chk("bp_ready", 32'(bus.o_ready), 32'h0);
        chk("bp_stable", bus.o_instr, held);
        chk("bp_instr0", bus.o_instr, 32'h04000013);
        while (k < 3) begin
            cyc(1'b1, bp_base[k], 32'h00000040 + 32'(k), 3'd1, 1'b1, a);
            if (a) k++;
        end
        idle(3);
        chk("bp_drained", 32'(q.size()), 32'(bus.o_valid));

        // Reset while both stages hold words
        cyc(1'b1, 32'h00000013, 32'h00000111, 3'd1, 1'b0, a);
        cyc(1'b1, 32'h00000013, 32'h00000222, 3'd1, 1'b0, a);
        cyc(1'b1, 32'h00000013, 32'h00000333, 3'd1, 1'b0, a);
        @(negedge clk);
        reset_n     = 1'b0;
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid_valid", 32'(bus.o_valid), 32'h0);
        chk("rstmid_cnt", 32'(bus.o_err_cnt), 32'h0);
        reset_n = 1'b1;
        q.delete();
        cnt_m = 0;
        cyc(1'b1, 32'h00000013, 32'h00000555, 3'd1, 1'b1, a);
        #1 chk("post_rst_early", 32'(bus.o_valid), 32'h0);
        cyc(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, a);
        #1 chk("post_rst_instr", bus.o_instr, 32'h55500013);
        chk("post_rst_valid", 32'(bus.o_valid), 32'h1);

        // Random traffic with random sink stalls
        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm;
            if ($urandom_range(0, 1) == 0) imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            else imm = $urandom;
            cyc($urandom_range(0, 3) != 0, $urandom, imm, 3'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, a);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
